// File: rtl/apa102_glyph_matrix_pkg.sv
// Shared types, constants and the pixel word packer for the APA102 glyph matrix driver.
package apa102_glyph_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        PIXEL,
        END
    } state_t;

    localparam int          START_BITS = 32;
    localparam int          PIX_BITS   = 32;
    localparam logic [2:0]  HDR        = 3'b111;

    // Glyph ROM entry 0, bit 0 of the glyph (top-left) is the MSB.
    localparam logic [63:0] GLYPH0     = 64'h0000780c7ccc7600;

    // APA102 LED frame: header, 5-bit global brightness, then B, G, R from a {R,G,B} colour.
    function automatic logic [31:0] pixel_word(input logic [4:0] bright, input logic [23:0] rgb);
        return {HDR, bright, rgb[7:0], rgb[15:8], rgb[23:16]};
    endfunction

endpackage

// File: rtl/apa102_glyph_matrix_if.sv
// Control/status and LED pin bundle between the host logic and the APA102 glyph matrix driver.
interface apa102_glyph_matrix_if #(
    parameter int NUM_GLYPHS = 4,
    parameter int COLS       = 8
);
    localparam int SEL_W = $clog2(NUM_GLYPHS);
    localparam int OFF_W = $clog2(COLS);

    logic             start;
    logic             repeat_en;
    logic             serp_en;
    logic [SEL_W-1:0] glyph_sel;
    logic [OFF_W-1:0] col_off;
    logic [4:0]       bright;
    logic [23:0]      fg_rgb;
    logic [23:0]      bg_rgb;
    logic             busy;
    logic             frame_done;
    logic             led_clk;
    logic             led_dat;

    modport master (
        output start, repeat_en, serp_en, glyph_sel, col_off, bright, fg_rgb, bg_rgb,
        input  busy, frame_done, led_clk, led_dat
    );

    modport slave (
        input  start, repeat_en, serp_en, glyph_sel, col_off, bright, fg_rgb, bg_rgb,
        output busy, frame_done, led_clk, led_dat
    );

endinterface

// File: rtl/apa102_glyph_matrix_glyph_rom.sv
// Combinational glyph ROM: entry 0 holds the built-in glyph, every other index reads blank.
module apa102_glyph_matrix_glyph_rom
    import apa102_glyph_matrix_pkg::*;
#(
    parameter int NUM_GLYPHS = 4,
    parameter int NPIX       = 64
) (
    input  logic [$clog2(NUM_GLYPHS)-1:0] glyph_sel_i,
    output logic [NPIX-1:0]               glyph_o
);

    // The 64-bit glyph is MSB-aligned into the NPIX-bit word so bit 0 stays top-left.
    localparam logic [NPIX+63:0] PADDED = {GLYPH0, {NPIX{1'b0}}};
    localparam logic [NPIX-1:0]  ENTRY0 = PADDED[NPIX+63 -: NPIX];

    // Only entry 0 is populated; blank and out-of-range entries render as all background.
    always_comb begin
        glyph_o = (glyph_sel_i == '0) ? ENTRY0 : '0;
    end

endmodule

// File: rtl/apa102_glyph_matrix.sv
// APA102 LED-matrix driver: streams start frame, one glyph as NPIX pixel words, then an end frame.
module apa102_glyph_matrix
    import apa102_glyph_matrix_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int NUM_GLYPHS = 4,
    parameter int CLK_DIV    = 1,
    parameter int END_BITS   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    apa102_glyph_matrix_if.slave  bus
);

    localparam int NPIX    = ROWS * COLS;
    localparam int SEL_W   = $clog2(NUM_GLYPHS);
    localparam int OFF_W   = $clog2(COLS);
    localparam int PIX_W   = $clog2(NPIX);
    localparam int BIT_MAX = (END_BITS > PIX_BITS) ? END_BITS : PIX_BITS;
    localparam int BIT_W   = $clog2(BIT_MAX);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t             state_q, state_d;
    logic               startPend_q;
    logic [DIV_W-1:0]   divCnt_q, divCnt_d;
    logic               phase_q, phase_d;
    logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [PIX_W-1:0]   pixCnt_q, pixCnt_d;
    logic [PIX_BITS-1:0] shift_q, shift_d;
    logic               frameDone_q, frameDone_d;
    logic [SEL_W-1:0]   glyphSel_q, glyphSel_d;
    logic [OFF_W-1:0]   colOff_q, colOff_d;
    logic               serp_q, serp_d;
    logic [4:0]         bright_q, bright_d;
    logic [23:0]        fg_q, fg_d;
    logic [23:0]        bg_q, bg_d;

    logic [NPIX-1:0]     glyphWord;
    logic [PIX_BITS-1:0] pixWord;
    logic accept, lastDiv, bitEnd, startLast, wordLast, endLast, pixLast, frameEnd, relatch;

    apa102_glyph_matrix_glyph_rom #(
        .NUM_GLYPHS (NUM_GLYPHS),
        .NPIX       (NPIX)
    ) u_rom (
        .glyph_sel_i (glyphSel_q),
        .glyph_o     (glyphWord)
    );

    assign accept    = bus.start && (state_q == IDLE) && !startPend_q;
    assign lastDiv   = (divCnt_q == DIV_W'(CLK_DIV - 1));
    assign bitEnd    = (state_q != IDLE) && phase_q && lastDiv;
    assign startLast = (bitCnt_q == BIT_W'(START_BITS - 1));
    assign wordLast  = (bitCnt_q == BIT_W'(PIX_BITS - 1));
    assign endLast   = (bitCnt_q == BIT_W'(END_BITS - 1));
    assign pixLast   = (pixCnt_q == PIX_W'(NPIX - 1));
    assign frameEnd  = (state_q == END) && bitEnd && endLast;
    assign relatch   = accept || (frameEnd && bus.repeat_en);

    // State register; an accepted start is held one cycle so the frame begins on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            startPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            startPend_q <= accept;
        end
    end

    // Next-state: walk start frame, pixel words and end frame, looping straight back on auto-repeat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startPend_q) state_d = START;
            START:   if (bitEnd && startLast) state_d = PIXEL;
            PIXEL:   if (bitEnd && wordLast && pixLast) state_d = END;
            END:     if (frameEnd) state_d = bus.repeat_en ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: led_clk follows the bit phase, led_dat is the MSB of the word being shifted out.
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.led_clk    = phase_q;
        bus.led_dat    = shift_q[PIX_BITS-1];
        bus.frame_done = frameDone_q;
    end

    // Colour of the next pixel word: chain index -> row/column, serpentine flip, scroll wrap, glyph lookup.
    always_comb begin
        int p, r, c, cs, cg, k;
        logic [NPIX-1:0] shifted;
        p       = (state_q == PIXEL) ? int'(pixCnt_q) + 1 : 0;
        r       = p / COLS;
        c       = p % COLS;
        cs      = (serp_q && (r % 2 == 0)) ? COLS - 1 - c : c;
        cg      = (cs + int'(colOff_q)) % COLS;
        k       = r * COLS + cg;
        shifted = glyphWord << k;
        pixWord = pixel_word(bright_q, shifted[NPIX-1] ? fg_q : bg_q);
    end

    // Datapath next-state: clock divider, bit/pixel counters, shift register and config latch.
    always_comb begin
        divCnt_d    = divCnt_q;
        phase_d     = phase_q;
        bitCnt_d    = bitCnt_q;
        pixCnt_d    = pixCnt_q;
        shift_d     = shift_q;
        frameDone_d = frameEnd;
        glyphSel_d  = glyphSel_q;
        colOff_d    = colOff_q;
        serp_d      = serp_q;
        bright_d    = bright_q;
        fg_d        = fg_q;
        bg_d        = bg_q;

        if (state_q != IDLE) begin
            if (!lastDiv) begin
                divCnt_d = divCnt_q + DIV_W'(1);
            end else begin
                divCnt_d = '0;
                phase_d  = ~phase_q;
                if (phase_q) begin
                    shift_d  = shift_q << 1;
                    bitCnt_d = bitCnt_q + BIT_W'(1);
                    if (state_q == START && startLast) begin
                        bitCnt_d = '0;
                        shift_d  = pixWord;
                    end
                    if (state_q == PIXEL && wordLast) begin
                        bitCnt_d = '0;
                        pixCnt_d = pixLast ? '0 : pixCnt_q + PIX_W'(1);
                        shift_d  = pixLast ? '0 : pixWord;
                    end
                    if (frameEnd) begin
                        bitCnt_d = '0;
                    end
                end
            end
        end

        if (relatch) begin
            glyphSel_d = bus.glyph_sel;
            colOff_d   = bus.col_off;
            serp_d     = bus.serp_en;
            bright_d   = bus.bright;
            fg_d       = bus.fg_rgb;
            bg_d       = bus.bg_rgb;
        end
    end

    // Datapath registers; reset clears everything so an aborted frame leaves the pins low.
    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt_q    <= '0;
            phase_q     <= 1'b0;
            bitCnt_q    <= '0;
            pixCnt_q    <= '0;
            shift_q     <= '0;
            frameDone_q <= 1'b0;
            glyphSel_q  <= '0;
            colOff_q    <= '0;
            serp_q      <= 1'b0;
            bright_q    <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
        end else begin
            divCnt_q    <= divCnt_d;
            phase_q     <= phase_d;
            bitCnt_q    <= bitCnt_d;
            pixCnt_q    <= pixCnt_d;
            shift_q     <= shift_d;
            frameDone_q <= frameDone_d;
            glyphSel_q  <= glyphSel_d;
            colOff_q    <= colOff_d;
            serp_q      <= serp_d;
            bright_q    <= bright_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
        end
    end

endmodule
